// File: rtl/note_scheduler.sv
// note_scheduler: pause-aware beat clock plus chart sequencer that offers arrow-spawn
// events LEAD_BEATS ahead of each entry's target beat.
module note_scheduler #(
    parameter int TICKS_PER_BEAT = 25_000_000,
    parameter int LEAD_BEATS     = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int BEAT_WIDTH     = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  game_active,
    input  logic                  paused,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [BEAT_WIDTH+4:0] rom_data,
    output logic                  spawn_valid,
    input  logic                  spawn_ready,
    output logic [3:0]            spawn_arrows,
    output logic [BEAT_WIDTH-1:0] spawn_beat,
    output logic [BEAT_WIDTH-1:0] beat_count,
    output logic                  beat_tick,
    output logic                  chart_done
);
    localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_COMPARE, S_EMIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;
    logic                  pulse_q, pulse_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_WIDTH+4:0] entry_q, entry_d;
    logic                  done_q, done_d;
    logic                  run, wrap, beat_inc, due, advance;

    wire                  entry_end    = entry_q[BEAT_WIDTH+4];
    wire [3:0]            entry_arrows = entry_q[BEAT_WIDTH+3:BEAT_WIDTH];
    wire [BEAT_WIDTH-1:0] entry_beat   = entry_q[BEAT_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            beat_q  <= '0;
            pulse_q <= 1'b0;
            addr_q  <= '0;
            entry_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            beat_q  <= beat_d;
            pulse_q <= pulse_d;
            addr_q  <= addr_d;
            entry_q <= entry_d;
            done_q  <= done_d;
        end
    end

    // Beat clock: frozen while idle or paused; beat_count saturates at all-ones.
    assign run      = (state_q != S_IDLE) && !paused;
    assign wrap     = tick_q == TW'(TICKS_PER_BEAT - 1);
    assign beat_inc = run && wrap && (beat_q != '1);
    // Widened by one bit so a chart near the top of the beat range never wraps.
    assign due      = ({1'b0, beat_q} + (BEAT_WIDTH+1)'(LEAD_BEATS)) >= {1'b0, entry_beat};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        entry_d = entry_q;
        done_d  = done_q;
        advance = 1'b0;
        tick_d  = run ? (wrap ? '0 : tick_q + 1'b1) : tick_q;
        beat_d  = beat_inc ? beat_q + 1'b1 : beat_q;
        pulse_d = beat_inc;
        if (paused) begin
            state_d = state_q;
        end else if (state_q != S_IDLE && !game_active) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (game_active) begin
                    tick_d  = '0;
                    beat_d  = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    state_d = S_FETCH;
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    entry_d = rom_data;
                    state_d = S_COMPARE;
                end
                S_COMPARE: begin
                    if (entry_end) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (entry_arrows == 4'd0) begin
                        advance = 1'b1;
                    end else if (due) begin
                        state_d = S_EMIT;
                    end
                end
                S_EMIT: advance = spawn_ready;
                S_DONE: done_d = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end
        // The last ROM address ends the chart rather than wrapping back to entry 0.
        if (advance) begin
            if (addr_q == '1) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    always_comb begin
        rom_addr     = addr_q;
        spawn_valid  = (state_q == S_EMIT) && !paused;
        spawn_arrows = entry_arrows;
        spawn_beat   = entry_beat;
        beat_count   = beat_q;
        beat_tick    = pulse_q;
        chart_done   = done_q;
    end
endmodule
